freelist_init_seq: RTL and testbench
====================================

FREELIST_INIT_SEQ -- requirements
Module: freelist_init_seq

Interface
REQ-001 The block SHALL have parameter DEPTH, default 32: number of free-list RAM entries.
REQ-002 The block SHALL have parameter INDEX, default 5: width of the free-list RAM address, log2(DEPTH).
REQ-003 The block SHALL have parameter PHYS_LOG, default 6: width of a physical register id.
REQ-004 The block SHALL have parameter LANES, default 4, range 1-4: number of RAM write ports driven per cycle.
REQ-005 The block SHALL have port clk, input, 1 bit: clock.
REQ-006 The block SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-007 The block SHALL have port start_i, input, 1 bit: request to re-initialise, e.g. after an RF partition resize.
REQ-008 The block SHALL have port size_i, input, INDEX+1 bits: number of active free-list entries.
REQ-009 The block SHALL have port base_i, input, PHYS_LOG bits: first free physical register id, equal to the number of logical registers.
REQ-010 The block SHALL have port drain_i, input, 1 bit: rename/commit pipeline empty; no pops or pushes are in flight.
REQ-011 The block SHALL have port we_o, output, LANES bits: per-lane RAM write enable.
REQ-012 The block SHALL have port addr_o[0:LANES-1], output, INDEX bits each: per-lane write address.
REQ-013 The block SHALL have port data_o[0:LANES-1], output, PHYS_LOG bits each: per-lane write data.
REQ-014 The block SHALL have port busy_o, output, 1 bit: initialisation in progress; rename stalls and free-list writes from commit are suppressed.
REQ-015 The block SHALL have port done_o, output, 1 bit: one-cycle pulse telling the free list to load count=size, head=0, tail=0.
REQ-016 The block SHALL have port size_o, output, INDEX+1 bits: latched effective size, held stable outside FILL.
REQ-017 The block SHALL have port ready_o, output, 1 bit: free-list contents valid.

Function
REQ-018 The block SHALL implement the states IDLE, WAIT_DRAIN, FILL and DONE.
REQ-019 In IDLE, start_i=1 SHALL latch the effective size into size_o and move the FSM to WAIT_DRAIN; the same edge SHALL clear ready_o.
REQ-020 The effective size SHALL be size_i, except that size_i=0 or size_i>DEPTH SHALL be clamped to DEPTH.
REQ-021 In WAIT_DRAIN, the FSM SHALL remain until drain_i=1, then enter FILL with ptr=0.
REQ-022 In FILL, for each lane k, we_o[k] SHALL equal (ptr+k < size_o), addr_o[k] SHALL be ptr+k, and data_o[k] SHALL be base_i+ptr+k truncated to PHYS_LOG bits.
REQ-023 In FILL, ptr (INDEX+1 bits) SHALL advance by LANES each cycle; when ptr+LANES >= size_o the FSM SHALL move to DONE on the next edge.
REQ-024 FILL SHALL last ceil(size_o/LANES) cycles.
REQ-025 In DONE, done_o SHALL be 1 for exactly one cycle; the FSM SHALL then return to IDLE and ready_o SHALL go to 1.
REQ-026 busy_o SHALL be 1 in WAIT_DRAIN, FILL and DONE.
REQ-027 Outside FILL, we_o SHALL be 0, and addr_o and data_o SHALL be 0.
REQ-028 start_i SHALL be ignored in any state other than IDLE.
REQ-029 Changes on size_i or base_i while busy_o=1 SHALL be ignored; base_i SHALL be latched together with size.

Reset
REQ-030 On reset: state=FILL, ptr=0, size_o=effective size_i, base latched from base_i, we_o=0, done_o=0, ready_o=0, busy_o=1.
REQ-031 After reset deassertion, the block SHALL fill without waiting for drain_i.
REQ-032 Reset asserted mid-operation SHALL abort the operation and restart the fill from address 0.

Configuration
REQ-033 With FREELIST_INIT_PERF_EN defined, output initCycles_o (16 bits) SHALL count the cycles busy_o=1 during the last initialisation, saturate at 0xFFFF, and hold its value in IDLE.
REQ-034 With FREELIST_INIT_PERF_EN defined, initCycles_o SHALL be cleared when start_i is accepted and on reset.
REQ-035 Without FREELIST_INIT_PERF_EN, the initCycles_o port and its counter SHALL be absent.

Structure
REQ-036 The FSM state enum and the lane-count constant SHALL be defined in the shared rename package.
REQ-037 The block SHALL have no sub-modules; one FSM and one pointer register suffice.

Verification
REQ-038 Bench SHALL cover: DEPTH=32, LANES=4, base_i=32, reset released -> 8 FILL cycles writing addr 0..31 / data 32..63, done_o pulse in cycle 9, then ready_o=1.
REQ-039 Bench SHALL cover: start_i with size_i=30 -> 8 FILL cycles, last cycle we_o=0011 at addr 28,29, size_o=30.
REQ-040 Bench SHALL cover: start_i with drain_i=0 for 5 cycles -> busy_o=1, we_o=0 for 5 cycles, FILL starts on the cycle after drain_i=1.
REQ-041 Bench SHALL cover: start_i pulsed in cycle 3 of FILL -> ignored, and exactly one done_o pulse.
REQ-042 Bench SHALL cover: reset asserted in cycle 3 of FILL -> we_o=0 immediately; after release, writes restart at addr 0.
REQ-043 Bench SHALL cover: size_i=0 and size_i=40 -> both clamp to size_o=32.

Source files
------------

// File: rtl/freelist_init_seq_pkg.sv
// freelist_init_seq_pkg -- shared rename definitions used by the free-list
// initialisation sequencer.
//   fl_state_t / ST_*  : sequencer FSM state encoding
//   FL_LANES           : number of free-list RAM write ports driven per cycle
package freelist_init_seq_pkg;

  typedef logic [1:0] fl_state_t;

  localparam fl_state_t ST_IDLE       = 2'd0;
  localparam fl_state_t ST_WAIT_DRAIN = 2'd1;
  localparam fl_state_t ST_FILL       = 2'd2;
  localparam fl_state_t ST_DONE       = 2'd3;

  localparam int FL_LANES = 4;

endpackage

// File: rtl/freelist_init_seq.sv
// freelist_init_seq -- writes the free list with the ids of all free physical
// registers (base, base+1, ...) after reset or on request, LANES entries per
// cycle, then pulses done_o so the free list loads count=size, head=tail=0.
//
// Optional build macro: FREELIST_INIT_PERF_EN adds initCycles_o, the number of
// busy cycles of the last initialisation (saturating at 0xFFFF).
//
// Ports
//   clk, reset     : clock, asynchronous active-high reset (reset starts a fill)
//   start_i        : re-initialise request, honoured only when idle
//   size_i         : requested number of entries (0 or >DEPTH means DEPTH)
//   base_i         : first free physical register id
//   drain_i        : rename/commit pipeline empty
//   we_o           : per-lane RAM write enable
//   addr_o, data_o : per-lane RAM write address / data
//   busy_o         : initialisation in progress
//   done_o         : one-cycle completion pulse
//   size_o         : latched effective size
//   ready_o        : free-list contents valid
module freelist_init_seq
  import freelist_init_seq_pkg::*;
#(
  parameter int DEPTH    = 32,
  parameter int INDEX    = 5,
  parameter int PHYS_LOG = 6,
  parameter int LANES    = FL_LANES
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start_i,
  input  logic [INDEX:0]      size_i,
  input  logic [PHYS_LOG-1:0] base_i,
  input  logic                drain_i,
  output logic [LANES-1:0]    we_o,
  output logic [INDEX-1:0]    addr_o [0:LANES-1],
  output logic [PHYS_LOG-1:0] data_o [0:LANES-1],
  output logic                busy_o,
  output logic                done_o,
  output logic [INDEX:0]      size_o,
  output logic                ready_o
`ifdef FREELIST_INIT_PERF_EN
  ,
  output logic [15:0]         initCycles_o
`endif
);

  localparam logic [INDEX:0]   DEPTH_V = DEPTH[INDEX:0];
  localparam logic [INDEX+1:0] LANES_V = (INDEX + 2)'(LANES);

  fl_state_t           state;
  logic [INDEX:0]      ptr;
  logic [INDEX:0]      size_q;
  logic [PHYS_LOG-1:0] base_q;
  logic                ready_q;

  logic [INDEX+1:0]    ptr_ext;
  logic [INDEX+1:0]    size_ext;
  logic [INDEX+1:0]    ptr_next;
  logic                fill_last;
  logic                fill_active;

  function automatic logic [INDEX:0] eff_size(input logic [INDEX:0] s);
    if (s == '0 || s > DEPTH_V) return DEPTH_V;
    return s;
  endfunction

  // One guard bit so ptr+LANES never wraps before the end-of-fill compare.
  assign ptr_ext   = {1'b0, ptr};
  assign size_ext  = {1'b0, size_q};
  assign ptr_next  = ptr_ext + LANES_V;
  assign fill_last = (ptr_next >= size_ext);

  // The state sits in FILL while reset is held, so the write lanes are also
  // gated by reset to keep the RAM quiet until the fill really starts.
  assign fill_active = (state == ST_FILL) && !reset;

  // Control FSM, fill pointer and latched size/base. Reset lands directly in
  // FILL so the free list is rebuilt without waiting for drain_i.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_FILL;
      ptr     <= '0;
      size_q  <= eff_size(size_i);
      base_q  <= base_i;
      ready_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            state   <= ST_WAIT_DRAIN;
            size_q  <= eff_size(size_i);
            base_q  <= base_i;
            ready_q <= 1'b0;
          end
        end
        ST_WAIT_DRAIN: begin
          if (drain_i) begin
            state <= ST_FILL;
            ptr   <= '0;
          end
        end
        ST_FILL: begin
          ptr <= ptr_next[INDEX:0];
          if (fill_last) state <= ST_DONE;
        end
        default: begin
          state   <= ST_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Write lanes: lane k covers entry ptr+k; the final cycle may be partial.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [INDEX+1:0] idx;
    assign idx       = ptr_ext + (INDEX + 2)'(k);
    assign we_o[k]   = fill_active && (idx < size_ext);
    assign addr_o[k] = fill_active ? idx[INDEX-1:0] : '0;
    assign data_o[k] = fill_active ? PHYS_LOG'(base_q + PHYS_LOG'(idx)) : '0;
  end

  assign busy_o  = (state != ST_IDLE);
  assign done_o  = (state == ST_DONE);
  assign size_o  = size_q;
  assign ready_o = ready_q;

`ifdef FREELIST_INIT_PERF_EN
  logic [15:0] cyc_q;

  // Counts every busy cycle; cleared when a new request is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc_q <= '0;
    end else if (state == ST_IDLE) begin
      if (start_i) cyc_q <= '0;
    end else if (cyc_q != 16'hFFFF) begin
      cyc_q <= cyc_q + 16'd1;
    end
  end

  assign initCycles_o = cyc_q;
`endif

endmodule

// File: tb/tb_freelist_init_seq.sv
// tb_freelist_init_seq -- scoreboard bench for freelist_init_seq with default
// parameters (DEPTH=32, INDEX=5, PHYS_LOG=6, LANES=4).
module tb_freelist_init_seq;

  logic       clk;
  logic       reset;
  logic       start_i;
  logic [5:0] size_i;
  logic [5:0] base_i;
  logic       drain_i;
  logic [3:0] we_o;
  logic [4:0] addr_o [0:3];
  logic [5:0] data_o [0:3];
  logic       busy_o;
  logic       done_o;
  logic [5:0] size_o;
  logic       ready_o;
`ifdef FREELIST_INIT_PERF_EN
  logic [15:0] init_cycles;
`endif

  freelist_init_seq dut (
    .clk     (clk),
    .reset   (reset),
    .start_i (start_i),
    .size_i  (size_i),
    .base_i  (base_i),
    .drain_i (drain_i),
    .we_o    (we_o),
    .addr_o  (addr_o),
    .data_o  (data_o),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .size_o  (size_o),
    .ready_o (ready_o)
`ifdef FREELIST_INIT_PERF_EN
    ,
    .initCycles_o (init_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] addr;
    logic [5:0] data;
  } wr_t;

  wr_t sb[$];
  int  checks = 0;
  int  errors = 0;

  // Results of the last run_fill call.
  int         fill_cyc, first_fill, done_at, done_cnt;
  logic [3:0] last_we;
  int         last_addr0, last_addr1;
  logic       ready_after, busy_after;

  task automatic push_fill(input int n, input int base);
    wr_t w;
    for (int a = 0; a < n; a++) begin
      w.addr = a[4:0];
      w.data = 6'(base + a);
      sb.push_back(w);
    end
  endtask

  // Samples on the falling edge, pops the scoreboard for every enabled lane,
  // optionally pulses start_i or asserts reset at a given fill cycle.
  task automatic run_fill(input int budget, input int start_at, input int abort_at);
    wr_t e;
    bit  fin;
    fin = 0;
    fill_cyc = 0; first_fill = -1; done_at = -1; done_cnt = 0;
    last_we = '0; last_addr0 = -1; last_addr1 = -1;
    ready_after = 1'b0; busy_after = 1'b1;
    for (int n = 1; n <= budget && !fin; n++) begin
      @(negedge clk);
      start_i = 1'b0;
      if (done_o === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = n;
      end else if (done_at >= 0) begin
        fin = 1;
        ready_after = ready_o;
        busy_after = busy_o;
      end
      if (we_o !== 4'b0000) begin
        fill_cyc++;
        if (first_fill < 0) first_fill = n;
        last_we = we_o;
        last_addr0 = int'(addr_o[0]);
        last_addr1 = int'(addr_o[1]);
        for (int k = 0; k < 4; k++) begin
          if (we_o[k] === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
              errors++;
              $display("FAIL write_unexpected lane %0d: got addr %0d data %0d, none expected",
                       k, addr_o[k], data_o[k]);
            end else begin
              e = sb.pop_front();
              if (addr_o[k] !== e.addr || data_o[k] !== e.data) begin
                errors++;
                $display("FAIL write lane %0d: got addr %0d data %0d, expected addr %0d data %0d",
                         k, addr_o[k], data_o[k], e.addr, e.data);
              end
            end
          end
        end
        if (start_at > 0 && fill_cyc == start_at) begin
          start_i = 1'b1;
          size_i  = 6'd8;
          base_i  = 6'd1;
        end
        if (abort_at > 0 && fill_cyc == abort_at) begin
          reset = 1'b1;
          #1;
          checks++;
          if (we_o !== 4'b0000 || busy_o !== 1'b1 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL abort_outputs: got we %b busy %b done %b, expected we 0000 busy 1 done 0",
                     we_o, busy_o, done_o);
          end
          fin = 1;
        end
      end
    end
    checks++;
    if (!fin) begin
      errors++;
      $display("FAIL fill_timeout: no completion within %0d cycles", budget);
    end
  endtask

  task automatic check_sb_empty(input string name);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_sb_left: %0d writes outstanding, expected 0", name, sb.size());
    end
    sb.delete();
  endtask

  task automatic start_req(input logic [5:0] sz, input logic [5:0] bs);
    @(negedge clk);
    start_i = 1'b1;
    size_i  = sz;
    base_i  = bs;
  endtask

  task automatic test_reset();
    reset = 1'b1; start_i = 1'b0; size_i = 6'd32; base_i = 6'd32; drain_i = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (we_o !== 4'b0000 || done_o !== 1'b0 || ready_o !== 1'b0 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_ctrl: got we %b done %b ready %b busy %b, expected 0000 0 0 1",
               we_o, done_o, ready_o, busy_o);
    end
    checks++;
    if (size_o !== 6'd32) begin
      errors++;
      $display("FAIL reset_size: got %0d expected 32", size_o);
    end
    push_fill(32, 32);
    @(posedge clk);
    #1 reset = 1'b0;
    run_fill(40, 0, 0);
    checks++;
    if (fill_cyc != 8 || first_fill != 1 || done_at != 9 || done_cnt != 1) begin
      errors++;
      $display("FAIL reset_fill_timing: got fill %0d first %0d done_at %0d dones %0d, expected 8 1 9 1",
               fill_cyc, first_fill, done_at, done_cnt);
    end
    checks++;
    if (ready_after !== 1'b1 || busy_after !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: got ready %b busy %b, expected 1 0", ready_after, busy_after);
    end
    check_sb_empty("reset");
  endtask

  task automatic test_size30();
    drain_i = 1'b1;
    start_req(6'd30, 6'd32);
    push_fill(30, 32);
    @(negedge clk);
    start_i = 1'b0;
    checks++;
    if (busy_o !== 1'b1 || ready_o !== 1'b0 || size_o !== 6'd30) begin
      errors++;
      $display("FAIL size30_accept: got busy %b ready %b size %0d, expected 1 0 30",
               busy_o, ready_o, size_o);
    end
    run_fill(40, 0, 0);
    checks++;
    if (fill_cyc != 8 || done_at != 9 || done_cnt != 1) begin
      errors++;
      $display("FAIL size30_timing: got fill %0d done_at %0d dones %0d, expected 8 9 1",
               fill_cyc, done_at, done_cnt);
    end
    checks++;
    if (last_we !== 4'b0011 || last_addr0 != 28 || last_addr1 != 29) begin
      errors++;
      $display("FAIL size30_last: got we %b addr %0d,%0d, expected 0011 28,29",
               last_we, last_addr0, last_addr1);
    end
    checks++;
    if (ready_after !== 1'b1) begin
      errors++;
      $display("FAIL size30_ready: got %b expected 1", ready_after);
    end
    check_sb_empty("size30");
  endtask

  task automatic test_wait_drain();
    drain_i = 1'b0;
    start_req(6'd16, 6'd10);
    push_fill(16, 10);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start_i = 1'b0;
      checks++;
      if (busy_o !== 1'b1 || we_o !== 4'b0000) begin
        errors++;
        $display("FAIL drain_wait_%0d: got busy %b we %b, expected 1 0000", i, busy_o, we_o);
      end
    end
    drain_i = 1'b1;
    run_fill(30, 0, 0);
    checks++;
    if (first_fill != 1 || fill_cyc != 4 || done_cnt != 1) begin
      errors++;
      $display("FAIL drain_fill: got first %0d fill %0d dones %0d, expected 1 4 1",
               first_fill, fill_cyc, done_cnt);
    end
    check_sb_empty("drain");
  endtask

  task automatic test_start_ignored();
    start_req(6'd32, 6'd32);
    push_fill(32, 32);
    @(negedge clk);
    start_i = 1'b0;
    run_fill(40, 3, 0);
    checks++;
    if (fill_cyc != 8 || done_cnt != 1 || size_o !== 6'd32) begin
      errors++;
      $display("FAIL start_ignored: got fill %0d dones %0d size %0d, expected 8 1 32",
               fill_cyc, done_cnt, size_o);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (busy_o !== 1'b0 || done_o !== 1'b0) begin
        errors++;
        $display("FAIL start_ignored_idle_%0d: got busy %b done %b, expected 0 0", i, busy_o, done_o);
      end
    end
    check_sb_empty("start_ignored");
  endtask

  task automatic test_reset_mid();
    start_req(6'd32, 6'd32);
    push_fill(32, 32);
    @(negedge clk);
    start_i = 1'b0;
    run_fill(40, 0, 3);
    sb.delete();
    size_i = 6'd32;
    base_i = 6'd7;
    @(negedge clk);
    checks++;
    if (size_o !== 6'd32 || ready_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_hold: got size %0d ready %b, expected 32 0", size_o, ready_o);
    end
    push_fill(32, 7);
    @(posedge clk);
    #1 reset = 1'b0;
    run_fill(40, 0, 0);
    checks++;
    if (fill_cyc != 8 || first_fill != 1 || done_cnt != 1) begin
      errors++;
      $display("FAIL reset_mid_refill: got fill %0d first %0d dones %0d, expected 8 1 1",
               fill_cyc, first_fill, done_cnt);
    end
    check_sb_empty("reset_mid");
  endtask

  task automatic test_clamp();
    logic [5:0] sizes [2];
    sizes[0] = 6'd0;
    sizes[1] = 6'd40;
    for (int s = 0; s < 2; s++) begin
      start_req(sizes[s], 6'd60);
      push_fill(32, 60);
      @(negedge clk);
      start_i = 1'b0;
      checks++;
      if (size_o !== 6'd32) begin
        errors++;
        $display("FAIL clamp_size_%0d: got %0d expected 32", sizes[s], size_o);
      end
      run_fill(40, 0, 0);
      checks++;
      if (fill_cyc != 8 || done_cnt != 1) begin
        errors++;
        $display("FAIL clamp_fill_%0d: got fill %0d dones %0d, expected 8 1",
                 sizes[s], fill_cyc, done_cnt);
      end
      check_sb_empty("clamp");
    end
  endtask

  initial begin
    test_reset();
    test_size30();
    test_wait_drain();
    test_start_ignored();
    test_reset_mid();
    test_clamp();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
